// File: rtl/bool_sweep_if.sv
// Handshake and result bundle between the sweep checker and the implementations under test.
// master = checker side, slave = environment that owns start and the f_* outputs.
interface bool_sweep_if #(
  parameter int unsigned N_IN = 3
);
  logic            start;
  logic [N_IN-1:0] vec_out;
  logic            f_dataflow;
  logic            f_behavioral;
  logic            f_structural;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [2:0]      fail_mask;
  logic [N_IN-1:0] first_fail_vec;
  logic            first_fail_valid;

  modport master (
    input  start, f_dataflow, f_behavioral, f_structural,
    output vec_out, busy, done, pass, err_count, fail_mask, first_fail_vec, first_fail_valid
  );

  modport slave (
    output start, f_dataflow, f_behavioral, f_structural,
    input  vec_out, busy, done, pass, err_count, fail_mask, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/bool_sweep_checker.sv
// Exhaustive input sweep for three Boolean-function implementations, checked against a
// golden truth table; reports error count, per-implementation fail flags and first failing vector.
module bool_sweep_checker #(
  parameter int unsigned              N_IN   = 3,
  parameter int unsigned              SETTLE = 2,
  parameter logic [(2**N_IN)-1:0]     TRUTH  = 8'hCA
) (
  input logic         clk,
  input logic         rst_n,
  bool_sweep_if.master bus
);

  localparam int unsigned     CntW    = $clog2(SETTLE + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

  state_e          state_q;
  logic [N_IN-1:0] vec_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   err_q;
  logic [2:0]      mask_q;
  logic [N_IN-1:0] ffv_q;
  logic            ffvalid_q;

  logic            golden;
  logic [2:0]      mis;
  logic [N_IN:0]   err_next;

  // Case inequality so an X/Z from an implementation is flagged as a mismatch.
  always_comb begin
    golden   = TRUTH[vec_q];
    mis      = {bus.f_dataflow !== golden, bus.f_behavioral !== golden,
                bus.f_structural !== golden};
    err_next = (|mis) ? err_q + 1'b1 : err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      vec_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      mask_q    <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            state_q   <= StDrive;
            vec_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            mask_q    <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
          end
        end
        StDrive: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_q <= StSample;
          end
        end
        StSample: begin
          err_q  <= err_next;
          mask_q <= mask_q | mis;
          if ((|mis) && !ffvalid_q) begin
            ffv_q     <= vec_q;
            ffvalid_q <= 1'b1;
          end
          if (vec_q == {N_IN{1'b1}}) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_next == '0);
          end else begin
            state_q <= StDrive;
            vec_q   <= vec_q + 1'b1;
            cnt_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.vec_out          = vec_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.fail_mask        = mask_q;
  assign bus.first_fail_vec   = ffv_q;
  assign bus.first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_bool_sweep_checker.sv
// Bench for bool_sweep_checker: stand-in implementations with injectable faults, a per-cycle
// model derived from F = AB + A'C and the sweep timing rules, and literal result pins.
module tb_bool_sweep_checker;

  localparam int NV  = 8;
  localparam int PER = 3;  // SETTLE + 1

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bool_sweep_if #(.N_IN(3)) bus ();
  bool_sweep_if #(.N_IN(2)) bus2 ();

  bool_sweep_checker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  bool_sweep_checker #(.N_IN(2), .SETTLE(1), .TRUTH(4'h8)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int checks = 0;
  int errors = 0;
  int mode = 0;
  int edge_cnt = 0;
  int start_edge = 0;
  bit active = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic gold(int v);
    logic a, b, c;
    a = v[2];
    b = v[1];
    c = v[0];
    return (a & b) | (~a & c);
  endfunction

  // Stand-in implementations: {dataflow, behavioral, structural}. Mode 2 uses a wrong value on
  // vector 5 for behavioral since X collapses in two-state simulation.
  function automatic logic [2:0] model_f(int m, int v);
    logic g;
    g = gold(v);
    case (m)
      1:       return {g, g, 1'b0};
      2:       return {~g, (v == 5) ? ~g : g, g};
      default: return {g, g, g};
    endcase
  endfunction

  always_comb begin
    {bus.f_dataflow, bus.f_behavioral, bus.f_structural} = model_f(mode, int'(bus.vec_out));
    bus2.f_dataflow   = &bus2.vec_out;
    bus2.f_behavioral = &bus2.vec_out;
    bus2.f_structural = &bus2.vec_out;
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Expected outputs k edges after the start-accepting edge, from results of completed vectors.
  always @(negedge clk) begin
    if (active) begin
      int k, comp, e, ffv, ev;
      bit fv;
      logic [2:0] mask, fb;
      k = edge_cnt - start_edge;
      comp = (k / PER > NV) ? NV : k / PER;
      e = 0; mask = 3'b000; fv = 1'b0; ffv = 0;
      for (int v = 0; v < comp; v++) begin
        fb = model_f(mode, v) ^ {3{gold(v)}};
        if (|fb) begin
          e++;
          mask |= fb;
          if (!fv) begin
            fv = 1'b1;
            ffv = v;
          end
        end
      end
      ev = (k < NV * PER) ? k / PER : NV - 1;
      chk("vec_out", int'(bus.vec_out), ev);
      chk("busy", int'(bus.busy), int'(k < NV * PER));
      chk("done", int'(bus.done), int'(k >= NV * PER));
      chk("pass", int'(bus.pass), int'(k >= NV * PER && e == 0));
      chk("err_count", int'(bus.err_count), e);
      chk("fail_mask", int'(bus.fail_mask), int'(mask));
      chk("first_fail_valid", int'(bus.first_fail_valid), int'(fv));
      chk("first_fail_vec", int'(bus.first_fail_vec), ffv);
    end
  end

  task automatic do_start(bit hold);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    start_edge = edge_cnt;
    active = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      errors++;
      $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", bus.done, n);
    end
    // Dropped before the next edge so a held start does not restart here.
    bus.start = 1'b0;
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_vec"}, int'(bus.vec_out), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_pass"}, int'(bus.pass), 0);
    chk({tag, "_err"}, int'(bus.err_count), 0);
    chk({tag, "_mask"}, int'(bus.fail_mask), 0);
    chk({tag, "_ffvec"}, int'(bus.first_fail_vec), 0);
    chk({tag, "_ffvalid"}, int'(bus.first_fail_valid), 0);
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus2.start = 1'b0;
    #2;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("idle");

    // Clean sweep.
    mode = 0;
    do_start(1'b0);
    wait_done();
    chk("clean_pass", int'(bus.pass), 1);
    chk("clean_err", int'(bus.err_count), 0);
    chk("clean_mask", int'(bus.fail_mask), 0);
    chk("clean_ffvalid", int'(bus.first_fail_valid), 0);
    repeat (3) @(negedge clk);
    active = 1'b0;

    // Structural stuck at 0.
    mode = 1;
    do_start(1'b0);
    wait_done();
    chk("stuck_err", int'(bus.err_count), 4);
    chk("stuck_mask", int'(bus.fail_mask), 3'b001);
    chk("stuck_ffvec", int'(bus.first_fail_vec), 1);
    chk("stuck_pass", int'(bus.pass), 0);
    active = 1'b0;

    // Dataflow inverted, behavioral wrong on vector 5.
    mode = 2;
    do_start(1'b0);
    wait_done();
    chk("multi_err", int'(bus.err_count), 8);
    chk("multi_mask", int'(bus.fail_mask), 3'b110);
    chk("multi_ffvec", int'(bus.first_fail_vec), 0);
    chk("multi_ffvalid", int'(bus.first_fail_valid), 1);
    active = 1'b0;

    // Reset mid-sweep at vector 4.
    mode = 1;
    do_start(1'b0);
    n = 0;
    while (bus.vec_out != 3'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vec4", int'(bus.vec_out), 4);
    #2;
    active = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    do_start(1'b0);
    wait_done();
    chk("post_abort_pass", int'(bus.pass), 1);
    active = 1'b0;

    // Start held through a failing sweep, then a DONE restart with clean implementations.
    mode = 1;
    do_start(1'b1);
    wait_done();
    chk("held_err", int'(bus.err_count), 4);
    active = 1'b0;
    mode = 0;
    do_start(1'b0);
    chk("restart_err_cleared", int'(bus.err_count), 0);
    chk("restart_done_low", int'(bus.done), 0);
    wait_done();
    chk("restart_pass", int'(bus.pass), 1);
    active = 1'b0;

    // Two-input AND variant, SETTLE=1.
    @(negedge clk);
    bus2.start = 1'b1;
    @(posedge clk);
    #1;
    bus2.start = 1'b0;
    n = 0;
    while (!bus2.done && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("and_cycles", n, 8);
    chk("and_pass", int'(bus2.pass), 1);
    chk("and_err", int'(bus2.err_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bool_sweep_checker.md
Name: bool_sweep_checker

Overview:
Clocked self-checking harness stage for the Boolean-function blocks. It sits upstream of the three implementations (dataflow, behavioral, structural) and drives their inputs through every input combination. It also consumes their outputs, comparing each against a golden truth table. It reports the error count, which implementations failed, and the first failing vector, so exhaustive sweeps run in synthesizable or emulated form instead of a delay-based bench loop.

Parameters:
N_IN, 3, number of function inputs; the sweep covers 2^N_IN vectors.
SETTLE, 2, cycles each vector is held before sampling; must be >= 1.
TRUTH, 8'hCA, golden truth table of width 2^N_IN; bit i = expected F for input vector i. The default encodes F = AB + A'C with {A,B,C} = i.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a sweep; sampled only in IDLE or DONE.
vec_out  output  N_IN  current input vector driven to the DUTs; MSB = A.
f_dataflow  input  1  output of the dataflow implementation.
f_behavioral  input  1  output of the behavioral implementation.
f_structural  input  1  output of the structural implementation.
busy  output  1  high while a sweep is in progress (DRIVE or SAMPLE).
done  output  1  high in DONE; held until the next accepted start or reset.
pass  output  1  valid when done=1; 1 iff err_count == 0.
err_count  output  N_IN+1  number of vectors with at least one mismatching implementation.
fail_mask  output  3  sticky per-implementation failure flags: bit2 dataflow, bit1 behavioral, bit0 structural.
first_fail_vec  output  N_IN  vector of the first mismatch.
first_fail_valid  output  1  high once first_fail_vec has been captured.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, first_fail_vec=0, first_fail_valid=0, settle counter=0. Reset mid-sweep aborts immediately, with no partial results retained.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE/DONE with start=1 at an edge:
  - go to DRIVE.
  - vec_out=0, settle counter=0, busy=1, done=0, pass=0.
  - clear err_count, fail_mask, first_fail_vec and first_fail_valid.
- DRIVE: vec_out held. The settle counter increments each cycle; after SETTLE cycles in DRIVE, go to SAMPLE.
- SAMPLE (one cycle): golden g = TRUTH[vec_out]. At the edge leaving SAMPLE:
  - Per implementation, mismatch = (f_x !== g); X or Z on a DUT output counts as a mismatch.
  - Any mismatch: err_count += 1, OR the per-implementation bits into fail_mask, and capture first_fail_vec=vec_out with first_fail_valid=1 if first_fail_valid was 0.
  - If vec_out == 2^N_IN-1: go to DONE, busy=0, done=1, pass=(final err_count==0). vec_out holds its last value.
  - Otherwise: vec_out += 1, settle counter=0, return to DRIVE.
- Timing: each vector occupies SETTLE+1 cycles. done rises exactly 2^N_IN*(SETTLE+1) cycles after the start-accepting edge (24 cycles for the defaults).
- start while busy is ignored. start held high in DONE restarts a sweep on the next edge.
- err_count width N_IN+1 holds the maximum 2^N_IN without wrap.
- Simultaneous mismatch in several implementations on one vector counts as one err_count increment, with several fail_mask bits set.
- All outputs are registered; there are no combinational paths from the f_* inputs to the outputs.

Test Plan:
- Reset then start pulse, all three DUTs correct (defaults) -> vec_out steps 0..7, each held 3 cycles; done=1 at cycle 24 after start; pass=1, err_count=0, fail_mask=000, first_fail_valid=0.
- Structural output forced to constant 0 -> err_count=4 (vectors 1, 3, 6, 7), fail_mask=001, first_fail_vec=1, pass=0.
- Dataflow inverted and behavioral driven to X on vector 5 only -> err_count=8, fail_mask=110, first_fail_vec=0.
- rst_n pulsed low while vec_out=4 -> all outputs return to reset values immediately. A fresh start then completes a clean 24-cycle sweep with pass=1.
- start held high throughout the sweep, and a second start issued in DONE -> start is ignored while busy. The DONE start clears err_count and the flags and re-runs; done drops for 24 cycles, then reasserts.
- SETTLE=1, N_IN=2, TRUTH=4'h8 (AND), with DUTs tied to a correct AND -> done after 8 cycles, pass=1.
